frame_swap_controller: RTL and testbench



---
 rtl/frame_swap_controller_pkg.sv | 24 ++
 rtl/frame_swap_controller_edge_detector.sv | 21 ++
 rtl/frame_swap_controller.sv | 135 +++++++++++++
 tb/tb_frame_swap_controller.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/frame_swap_controller_pkg.sv
// Shared types for the frame-store sequencer: FSM encoding and frame counter width.
`ifndef DISPLAY_WIDTH
`define DISPLAY_WIDTH 320
`endif
`ifndef DISPLAY_HEIGHT
`define DISPLAY_HEIGHT 240
`endif
`ifndef ADDR_BITS
`define ADDR_BITS 17
`endif

package frame_swap_controller_pkg;

  localparam int unsigned FRAME_COUNT_BITS = 16;

  typedef enum logic [2:0] {
    StRender     = 3'd0,
    StWaitVblank = 3'd1,
    StSwap       = 3'd2,
    StClear      = 3'd3,
    StStart      = 3'd4
  } fsc_state_t;

endpackage

// File: rtl/frame_swap_controller_edge_detector.sv
// Single-flop rising-edge detector: pulses for one cycle when level_in goes 0 -> 1.
module edge_detector (
  input  logic clk,
  input  logic rst,
  input  logic level_in,
  output logic rise_out
);

  logic level_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      level_q <= 1'b0;
    end else begin
      level_q <= level_in;
    end
  end

  assign rise_out = level_in & ~level_q;

endmodule

// File: rtl/frame_swap_controller.sv
// Sequences the double-buffered frame store: clear back buffer, hand off to renderer,
// then swap buffers on the next vertical-blank rising edge.
module frame_swap_controller
  import frame_swap_controller_pkg::*;
#(
  parameter int unsigned      WIDTH       = 4,
  parameter int unsigned      DEPTH       = `DISPLAY_WIDTH * `DISPLAY_HEIGHT,
  parameter int unsigned      ADDR_LEN    = `ADDR_BITS,
  parameter bit               CLEAR_EN    = 1'b1,
  parameter logic [WIDTH-1:0] CLEAR_VALUE = '0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        vblank_in,
  input  logic                        render_done_in,
  output logic                        render_start_out,
  input  logic                        render_wr_en_in,
  input  logic [ADDR_LEN-1:0]         render_wr_addr_in,
  input  logic [WIDTH-1:0]            render_wr_data_in,
  output logic                        write_enable_out,
  output logic [ADDR_LEN-1:0]         write_addr_out,
  output logic [WIDTH-1:0]            write_data_out,
  output logic                        swap_buffers_out,
  output logic [FRAME_COUNT_BITS-1:0] frame_count_out,
  output logic [2:0]                  state_out
);

  // Terminal count is DEPTH-1, not the counter's natural wrap point.
  localparam logic [ADDR_LEN-1:0] LastAddr   = ADDR_LEN'(DEPTH - 1);
  localparam fsc_state_t          ResetState = CLEAR_EN ? StClear : StStart;

  fsc_state_t                  state_q, state_d;
  logic [ADDR_LEN-1:0]         clr_cnt_q, clr_cnt_d;
  logic                        we_q, we_d;
  logic [ADDR_LEN-1:0]         addr_q, addr_d;
  logic [WIDTH-1:0]            data_q, data_d;
  logic                        swap_q, swap_d;
  logic                        start_q, start_d;
  logic [FRAME_COUNT_BITS-1:0] frame_count_q, frame_count_d;
  logic [2:0]                  state_out_q, state_out_d;
  logic                        vblank_rise;

  edge_detector u_vblank_edge (
    .clk      (clk),
    .rst      (rst),
    .level_in (vblank_in),
    .rise_out (vblank_rise)
  );

  // Outputs are registered actions of the current state, so state_out tracks them.
  always_comb begin
    state_d       = state_q;
    clr_cnt_d     = clr_cnt_q;
    we_d          = 1'b0;
    addr_d        = '0;
    data_d        = '0;
    swap_d        = 1'b0;
    start_d       = 1'b0;
    frame_count_d = frame_count_q;
    state_out_d   = state_q;

    case (state_q)
      StClear: begin
        we_d   = 1'b1;
        addr_d = clr_cnt_q;
        data_d = CLEAR_VALUE;
        if (clr_cnt_q == LastAddr) begin
          clr_cnt_d = '0;
          state_d   = StStart;
        end else begin
          clr_cnt_d = clr_cnt_q + ADDR_LEN'(1);
        end
      end
      StStart: begin
        start_d = 1'b1;
        state_d = StRender;
      end
      StRender: begin
        we_d   = render_wr_en_in;
        addr_d = render_wr_addr_in;
        data_d = render_wr_data_in;
        if (render_done_in) begin
          state_d = vblank_rise ? StSwap : StWaitVblank;
        end
      end
      StWaitVblank: begin
        if (vblank_rise) begin
          state_d = StSwap;
        end
      end
      StSwap: begin
        swap_d        = 1'b1;
        frame_count_d = frame_count_q + FRAME_COUNT_BITS'(1);
        state_d       = CLEAR_EN ? StClear : StStart;
      end
      default: begin
        state_d   = ResetState;
        clr_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ResetState;
      clr_cnt_q     <= '0;
      we_q          <= 1'b0;
      addr_q        <= '0;
      data_q        <= '0;
      swap_q        <= 1'b0;
      start_q       <= 1'b0;
      frame_count_q <= '0;
      state_out_q   <= '0;
    end else begin
      state_q       <= state_d;
      clr_cnt_q     <= clr_cnt_d;
      we_q          <= we_d;
      addr_q        <= addr_d;
      data_q        <= data_d;
      swap_q        <= swap_d;
      start_q       <= start_d;
      frame_count_q <= frame_count_d;
      state_out_q   <= state_out_d;
    end
  end

  assign render_start_out = start_q;
  assign write_enable_out = we_q;
  assign write_addr_out   = addr_q;
  assign write_data_out   = data_q;
  assign swap_buffers_out = swap_q;
  assign frame_count_out  = frame_count_q;
  assign state_out        = state_out_q;

endmodule

// File: tb/tb_frame_swap_controller.sv
// Bench for frame_swap_controller: three configurations share stimulus and are checked
// cycle by cycle against a reference model, plus directed vectors for the corner cases.
module tb_frame_swap_controller;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       vb = 1'b0;
  logic       done = 1'b0;
  logic       wr_en = 1'b0;
  logic [4:0] wr_addr = '0;
  logic [3:0] wr_data = '0;

  logic a_we, a_swap, a_start, b_we, b_swap, b_start, c_we, c_swap, c_start;
  logic [4:0] a_addr, c_addr;
  logic [3:0] b_addr;
  logic [3:0] a_data, b_data, c_data;
  logic [15:0] a_fc, b_fc, c_fc;
  logic [2:0] a_st, b_st, c_st;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  frame_swap_controller #(.WIDTH(4), .DEPTH(16), .ADDR_LEN(5), .CLEAR_EN(1'b1),
                          .CLEAR_VALUE(4'h0)) dut_a (
    .clk(clk), .rst(rst), .vblank_in(vb), .render_done_in(done),
    .render_start_out(a_start), .render_wr_en_in(wr_en), .render_wr_addr_in(wr_addr),
    .render_wr_data_in(wr_data), .write_enable_out(a_we), .write_addr_out(a_addr),
    .write_data_out(a_data), .swap_buffers_out(a_swap), .frame_count_out(a_fc),
    .state_out(a_st));

  frame_swap_controller #(.WIDTH(4), .DEPTH(10), .ADDR_LEN(4), .CLEAR_EN(1'b1),
                          .CLEAR_VALUE(4'h5)) dut_b (
    .clk(clk), .rst(rst), .vblank_in(vb), .render_done_in(done),
    .render_start_out(b_start), .render_wr_en_in(wr_en), .render_wr_addr_in(wr_addr[3:0]),
    .render_wr_data_in(wr_data), .write_enable_out(b_we), .write_addr_out(b_addr),
    .write_data_out(b_data), .swap_buffers_out(b_swap), .frame_count_out(b_fc),
    .state_out(b_st));

  frame_swap_controller #(.WIDTH(4), .DEPTH(16), .ADDR_LEN(5), .CLEAR_EN(1'b0),
                          .CLEAR_VALUE(4'h0)) dut_c (
    .clk(clk), .rst(rst), .vblank_in(vb), .render_done_in(done),
    .render_start_out(c_start), .render_wr_en_in(wr_en), .render_wr_addr_in(wr_addr),
    .render_wr_data_in(wr_data), .write_enable_out(c_we), .write_addr_out(c_addr),
    .write_data_out(c_data), .swap_buffers_out(c_swap), .frame_count_out(c_fc),
    .state_out(c_st));

  // Reference model: 'phase' is the spec's state number; outputs are what the
  // registered ports must show after the edge just taken.
  typedef struct {
    int phase;
    int cnt;
    bit vq;
    bit we;
    int addr;
    int data;
    bit swap;
    bit start;
    int fc;
    int st;
  } model_t;

  model_t m_a, m_b, m_c;

  function automatic model_t mstep(model_t m, int depth, bit clr_en, int cval, int amask,
                                   bit r, bit v, bit dn, bit we, int a, int d);
    model_t n;
    bit rise;
    n = '{default: 0};
    if (r) begin
      n.phase = clr_en ? 3 : 4;
      return n;
    end
    rise    = v && !m.vq;
    n.vq    = v;
    n.fc    = m.fc;
    n.cnt   = m.cnt;
    n.phase = m.phase;
    n.st    = m.phase;
    case (m.phase)
      3: begin
        n.we   = 1;
        n.addr = m.cnt;
        n.data = cval;
        if (m.cnt + 1 == depth) begin
          n.cnt   = 0;
          n.phase = 4;
        end else begin
          n.cnt = m.cnt + 1;
        end
      end
      4: begin
        n.start = 1;
        n.phase = 0;
      end
      0: begin
        n.we   = we;
        n.addr = a & amask;
        n.data = d;
        if (dn) n.phase = rise ? 2 : 1;
      end
      1: if (rise) n.phase = 2;
      default: begin
        n.swap  = 1;
        n.fc    = (m.fc + 1) % 65536;
        n.phase = clr_en ? 3 : 4;
      end
    endcase
    return n;
  endfunction

  task automatic cmp(string name, model_t m, bit we, int addr, int data, bit swap,
                     bit start, int fc, int st);
    bit ok;
    ok = (we == m.we) && (!m.we || (addr == m.addr && data == m.data)) &&
         (swap == m.swap) && (start == m.start) && (fc == m.fc) && (st == m.st);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s t=%0t got we=%0d addr=%0d data=%0d swap=%0d start=%0d fc=%0d st=%0d want we=%0d addr=%0d data=%0d swap=%0d start=%0d fc=%0d st=%0d",
               name, $time, we, addr, data, swap, start, fc, st,
               m.we, m.addr, m.data, m.swap, m.start, m.fc, m.st);
    end
  endtask

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s t=%0t got %0d want %0d", name, $time, act, exp);
    end
  endtask

  task automatic tick();
    bit r = rst;
    bit v = vb;
    bit dn = done;
    bit we = wr_en;
    int a = int'(wr_addr);
    int d = int'(wr_data);
    @(posedge clk);
    #1;
    m_a = mstep(m_a, 16, 1'b1, 0, 31, r, v, dn, we, a, d);
    m_b = mstep(m_b, 10, 1'b1, 5, 15, r, v, dn, we, a, d);
    m_c = mstep(m_c, 16, 1'b0, 0, 31, r, v, dn, we, a, d);
    cmp("model_a", m_a, a_we, int'(a_addr), int'(a_data), a_swap, a_start, int'(a_fc),
        int'(a_st));
    cmp("model_b", m_b, b_we, int'(b_addr), int'(b_data), b_swap, b_start, int'(b_fc),
        int'(b_st));
    cmp("model_c", m_c, c_we, int'(c_addr), int'(c_data), c_swap, c_start, int'(c_fc),
        int'(c_st));
  endtask

  task automatic wait_start(string name);
    bit seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      tick();
      if (a_start) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s got no render_start_out want pulse within 40 cycles", name);
    end
  endtask

  typedef struct {
    bit         en;
    logic [4:0] addr;
    logic [3:0] data;
    int         exp_we;
    int         exp_addr;
    int         exp_data;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int swaps;
    int pre;
    bit found;

    vecs[0] = '{1'b1, 5'd5,  4'hA, 1, 5,  10};
    vecs[1] = '{1'b0, 5'd3,  4'h3, 0, 0,  0};
    vecs[2] = '{1'b1, 5'd0,  4'hF, 1, 0,  15};
    vecs[3] = '{1'b1, 5'd31, 4'h1, 1, 31, 1};
    vecs[4] = '{1'b1, 5'd16, 4'h6, 1, 16, 6};
    vecs[5] = '{1'b0, 5'd7,  4'h9, 0, 0,  0};

    // Reset and the post-reset clear of all 16 addresses.
    rst = 1'b1;
    tick();
    tick();
    chk("rst_we", a_we, 0);
    chk("rst_fc", a_fc, 0);
    chk("rst_state", a_st, 0);
    chk("rst_start", a_start, 0);
    rst = 1'b0;
    wr_en = 1'b1;
    wr_addr = 5'd5;
    wr_data = 4'hA;
    for (int i = 0; i < 16; i++) begin
      tick();
      chk("clear_we", a_we, 1);
      chk("clear_addr", a_addr, i);
      chk("clear_data", a_data, 0);
      if (i == 0) chk("noclear_start", c_start, 1);
    end
    wr_en = 1'b0;
    tick();
    chk("start_pulse", a_start, 1);
    chk("start_no_write", a_we, 0);
    tick();
    chk("render_state", a_st, 0);
    chk("start_single", a_start, 0);

    // Renderer write forwarding with one cycle of latency.
    for (int i = 0; i < 6; i++) begin
      wr_en = vecs[i].en;
      wr_addr = vecs[i].addr;
      wr_data = vecs[i].data;
      tick();
      chk("fwd_we", a_we, vecs[i].exp_we);
      if (vecs[i].exp_we != 0) begin
        chk("fwd_addr", a_addr, vecs[i].exp_addr);
        chk("fwd_data", a_data, vecs[i].exp_data);
      end
    end
    wr_en = 1'b0;

    // Done with vblank low; vblank rises ten cycles later.
    done = 1'b1;
    tick();
    done = 1'b0;
    for (int i = 0; i < 9; i++) begin
      tick();
      chk("wait_no_swap", a_swap, 0);
      chk("wait_state", a_st, 1);
    end
    vb = 1'b1;
    tick();
    chk("swap_not_yet", a_swap, 0);
    tick();
    chk("swap_pulse", a_swap, 1);
    chk("swap_fc", a_fc, 1);
    chk("swap_state", a_st, 2);
    tick();
    chk("swap_single", a_swap, 0);
    chk("clear_after_swap_we", a_we, 1);
    chk("clear_after_swap_addr", a_addr, 0);
    wait_start("start_after_swap");

    // Done while vblank already held high: needs a fresh rising edge.
    tick();
    done = 1'b1;
    tick();
    done = 1'b0;
    swaps = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      swaps += int'(a_swap);
    end
    pre = swaps;
    vb = 1'b0;
    tick();
    tick();
    vb = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      swaps += int'(a_swap);
    end
    chk("held_vblank_no_swap", pre, 0);
    chk("held_vblank_one_swap", swaps, 1);
    chk("held_vblank_fc", a_fc, 2);

    // A done pulse during CLEAR is ignored.
    done = 1'b1;
    tick();
    done = 1'b0;
    wait_start("start_after_clear_done");
    chk("clear_done_fc", a_fc, 2);

    // Done coincident with a vblank rise goes straight to SWAP.
    vb = 1'b0;
    tick();
    done = 1'b1;
    vb = 1'b1;
    tick();
    done = 1'b0;
    chk("coinc_state_render", a_st, 0);
    tick();
    chk("coinc_state_swap", a_st, 2);
    chk("coinc_swap", a_swap, 1);
    chk("coinc_fc", a_fc, 3);

    // Reset while the clear counter holds 7.
    found = 1'b0;
    for (int i = 0; i < 12 && !found; i++) begin
      tick();
      if (a_we && a_addr == 5'd6 && a_st == 3'd3) found = 1'b1;
    end
    chk("reach_clear_addr6", int'(found), 1);
    rst = 1'b1;
    tick();
    chk("midclr_rst_we", a_we, 0);
    chk("midclr_rst_addr", a_addr, 0);
    chk("midclr_rst_fc", a_fc, 0);
    chk("midclr_rst_state", a_st, 0);
    chk("midclr_rst_swap", a_swap, 0);
    rst = 1'b0;
    tick();
    chk("restart_we", a_we, 1);
    chk("restart_addr", a_addr, 0);
    chk("restart_fc", a_fc, 0);
    chk("noclear_restart_start", c_start, 1);
    wait_start("start_after_reset");

    // Randomised traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      rst = ($urandom_range(0, 399) == 0);
      if ($urandom_range(0, 6) == 0) vb = ~vb;
      done = ($urandom_range(0, 11) == 0);
      wr_en = $urandom_range(0, 1) != 0;
      wr_addr = 5'($urandom_range(0, 31));
      wr_data = 4'($urandom_range(0, 15));
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
